axil_arb: RTL and testbench

AXIL_ARB -- requirements
Module: axil_arb

---
 rtl/axil_arb_pkg.sv | 20 ++
 rtl/axil_arb_if.sv | 39 +++
 rtl/axil_rr_pick2.sv | 21 ++
 rtl/axil_arb.sv | 128 ++++++++++++
 tb/tb_axil_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types for the two-port AXI-lite arbiter: FSM state encoding,
// requester port identifiers and the timeout counter width.
package axil_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_M0 = 1'b0,
        PORT_M1 = 1'b1
    } port_t;

    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int CNT_W = 16;

endpackage

// File: rtl/axil_arb_if.sv
// Bundle of the two requester ports, the bridge-side port and busy.
// The slave modport is the arbiter's view; master is the environment's view.
interface axil_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req_i, m1_req_i;
    logic              m0_we_i, m1_we_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic [DATA_W-1:0] m0_data_i, m1_data_i;
    logic [DATA_W-1:0] m0_data_o, m1_data_o;
    logic              m0_ack_o, m1_ack_o;
    logic              m0_err_o, m1_err_o;
    logic              s_req_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_data_o;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ack_i;
    logic              busy_o;

    modport slave (
        input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
        input  m0_addr_i, m1_addr_i, m0_data_i, m1_data_i,
        output m0_data_o, m1_data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        output s_req_o, s_we_o, s_addr_o, s_data_o,
        input  s_data_i, s_ack_i,
        output busy_o
    );

    modport master (
        output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
        output m0_addr_i, m1_addr_i, m0_data_i, m1_data_i,
        input  m0_data_o, m1_data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        input  s_req_o, s_we_o, s_addr_o, s_data_o,
        output s_data_i, s_ack_i,
        input  busy_o
    );
endinterface

// File: rtl/axil_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module axil_rr_pick2
    import axil_arb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last_grant,
    output port_t grant,
    output logic  valid
);
    always_comb begin
        valid = req0 | req1;
        grant = PORT_M0;
        if (req0 && req1) begin
            grant = (last_grant == PORT_M0) ? PORT_M1 : PORT_M0;
        end else if (req1) begin
            grant = PORT_M1;
        end
    end
endmodule

// File: rtl/axil_arb.sv
// Two-requester arbiter in front of a single-outstanding AXI-lite bridge:
// IDLE -> ISSUE -> WAIT -> RESP, with a WAIT-state timeout that completes with err.
module axil_arb
    import axil_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic      M_AXI_ACLK,
    input  logic      M_AXI_ARESETN,
    axil_arb_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    port_t             last_grant;
    port_t             grant;
    port_t             pick;
    logic              pick_vld;
    logic [CNT_W-1:0]  cnt;
    logic              s_req;
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic [1:0]        ack;
    logic [1:0]        err;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              done;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    axil_rr_pick2 u_pick (
        .req0       (bus.m0_req_i),
        .req1       (bus.m1_req_i),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_vld)
    );

    // An ack in the final WAIT cycle takes priority over the timeout.
    always_comb begin
        done     = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        if (state == ST_WAIT) begin
            if (bus.s_ack_i) begin
                done     = 1'b1;
                rsp_data = s_we ? '0 : bus.s_data_i;
            end else if (cnt == CNT_LAST) begin
                done    = 1'b1;
                rsp_err = 1'b1;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state      <= ST_IDLE;
            last_grant <= PORT_M1;
            grant      <= PORT_M0;
            cnt        <= '0;
            s_req      <= 1'b0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_data     <= '0;
            ack        <= 2'b00;
            err        <= 2'b00;
            data0      <= '0;
            data1      <= '0;
        end else begin
            s_req <= 1'b0;
            ack   <= 2'b00;
            case (state)
                ST_IDLE: begin
                    // Fields are sampled only here, so a waiting requester may change them freely.
                    if (pick_vld) begin
                        grant  <= pick;
                        s_we   <= (pick == PORT_M1) ? bus.m1_we_i   : bus.m0_we_i;
                        s_addr <= (pick == PORT_M1) ? bus.m1_addr_i : bus.m0_addr_i;
                        s_data <= (pick == PORT_M1) ? bus.m1_data_i : bus.m0_data_i;
                        s_req  <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        state <= ST_RESP;
                        if (grant == PORT_M1) begin
                            ack[1] <= 1'b1;
                            err[1] <= rsp_err;
                            data1  <= rsp_data;
                        end else begin
                            ack[0] <= 1'b1;
                            err[0] <= rsp_err;
                            data0  <= rsp_data;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_req_o   = s_req;
    assign bus.s_we_o    = s_we;
    assign bus.s_addr_o  = s_addr;
    assign bus.s_data_o  = s_data;
    assign bus.m0_ack_o  = ack[0];
    assign bus.m1_ack_o  = ack[1];
    assign bus.m0_err_o  = err[0];
    assign bus.m1_err_o  = err[1];
    assign bus.m0_data_o = data0;
    assign bus.m1_data_o = data1;
    assign bus.busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_axil_arb.sv
// Scoreboard bench for axil_arb: requesters and a bridge model drive stimulus,
// a negedge monitor predicts grants and checks every completion.
module tb_axil_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axil_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .bus           (bus)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          ack_order[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_served;
    logic        prev_req [2];
    logic        prev_we  [2];
    logic [31:0] prev_addr[2];
    logic [31:0] prev_data[2];
    logic        prev_sreq;
    logic [31:0] last_data[2];
    logic        last_err [2];
    logic        in_txn;
    int          txn_port;
    logic        txn_we;
    logic [31:0] txn_addr, txn_data;
    int          txn_start;
    int          txn_seq = 0;
    int          force_delay = 0;
    logic        force_data_en = 1'b0;
    logic [31:0] force_data = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] dout(int p);
        return (p == 1) ? bus.m1_data_o : bus.m0_data_o;
    endfunction
    function automatic logic eout(int p);
        return (p == 1) ? bus.m1_err_o : bus.m0_err_o;
    endfunction
    function automatic logic aout(int p);
        return (p == 1) ? bus.m1_ack_o : bus.m0_ack_o;
    endfunction

    task automatic set_m(int p, logic req, logic we, logic [31:0] addr, logic [31:0] data);
        if (p == 1) begin
            bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_data_i = data;
        end else begin
            bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_data_i = data;
        end
    endtask

    task automatic set_req(int p, logic req);
        if (p == 1) bus.m1_req_i = req;
        else        bus.m0_req_i = req;
    endtask

    // Monitor: grant prediction from the requests seen one cycle before s_req_o,
    // completion checking against the scoreboard, and hold/stability checks.
    initial begin
        exp_t       e;
        logic [1:0] ackv;
        int         gp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                last_served = 1;
                in_txn      = 1'b0;
                prev_sreq   = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    last_data[p] = '0;
                    last_err[p]  = 1'b0;
                    prev_req[p]  = 1'b0;
                end
            end else begin
                ackv = {bus.m1_ack_o, bus.m0_ack_o};
                if (ackv == 2'b11) begin
                    n_tests++; n_fail++;
                    $display("FAIL dual_ack: got both ack_o high, required at most one");
                end
                for (int p = 0; p < 2; p++) begin
                    if (ackv[p]) begin
                        if (exp_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL spurious_ack: port %0d acked at cycle %0d, required no ack", p, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("ack_port", 64'(p), 64'(e.port));
                            check("ack_data", dout(p), e.data);
                            check("ack_err", eout(p), e.err);
                            check("ack_cycle", 64'(cyc), 64'(e.cyc));
                        end
                        last_data[p] = dout(p);
                        last_err[p]  = eout(p);
                    end else begin
                        check("hold_data", dout(p), last_data[p]);
                        check("hold_err", eout(p), last_err[p]);
                    end
                end
                if (!bus.busy_o) in_txn = 1'b0;
                if (in_txn) begin
                    check("stable_we", bus.s_we_o, txn_we);
                    check("stable_addr", bus.s_addr_o, txn_addr);
                    check("stable_data", bus.s_data_o, txn_data);
                end
                if (bus.s_req_o) begin
                    check("sreq_one_cycle", prev_sreq, 1'b0);
                    if (prev_req[0] && prev_req[1]) gp = 1 - last_served;
                    else if (prev_req[1])           gp = 1;
                    else if (prev_req[0])           gp = 0;
                    else                            gp = -1;
                    if (gp < 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL spurious_sreq: s_req_o at cycle %0d, required none", cyc);
                    end else begin
                        check("grant_we", bus.s_we_o, prev_we[gp]);
                        check("grant_addr", bus.s_addr_o, prev_addr[gp]);
                        check("grant_data", bus.s_data_o, prev_data[gp]);
                        txn_port    = gp;
                        txn_we      = prev_we[gp];
                        txn_addr    = prev_addr[gp];
                        txn_data    = prev_data[gp];
                        txn_start   = cyc;
                        last_served = gp;
                        in_txn      = 1'b1;
                        txn_seq++;
                    end
                end
                prev_sreq    = bus.s_req_o;
                prev_req[0]  = bus.m0_req_i;  prev_req[1]  = bus.m1_req_i;
                prev_we[0]   = bus.m0_we_i;   prev_we[1]   = bus.m1_we_i;
                prev_addr[0] = bus.m0_addr_i; prev_addr[1] = bus.m1_addr_i;
                prev_data[0] = bus.m0_data_i; prev_data[1] = bus.m1_data_i;
            end
        end
    end

    // Bridge model: answers each s_req_o after d cycles; d > T means the ack arrives too late.
    initial begin
        exp_t        e;
        int          d;
        int          seen;
        logic [31:0] rd;
        seen = 0;
        bus.s_ack_i  = 1'b0;
        bus.s_data_i = '0;
        forever begin
            @(posedge clk); #1;
            if (txn_seq != seen) begin
                seen = txn_seq;
                d  = (force_delay > 0) ? force_delay : int'($urandom_range(1, T + 2));
                rd = force_data_en ? force_data : $urandom;
                e.port = txn_port;
                e.err  = (d > T);
                e.data = (txn_we || d > T) ? 32'h0 : rd;
                e.cyc  = txn_start + ((d > T) ? T : d) + 1;
                exp_q.push_back(e);
                if (d > 1) begin
                    repeat (d - 1) @(posedge clk);
                    #1;
                end
                bus.s_ack_i  = 1'b1;
                bus.s_data_i = rd;
                @(posedge clk); #1;
                bus.s_ack_i  = 1'b0;
                bus.s_data_i = $urandom;
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_ctrl"}, {bus.s_req_o, bus.busy_o, bus.m0_ack_o, bus.m1_ack_o,
                              bus.m0_err_o, bus.m1_err_o}, 64'h0);
        check({tag, "_mdata"}, {bus.m0_data_o, bus.m1_data_o}, 64'h0);
        check({tag, "_sfields"}, {bus.s_we_o, bus.s_addr_o}, 64'h0);
        check({tag, "_sdata"}, bus.s_data_o, 64'h0);
    endtask

    task automatic apply_reset(string tag);
        @(negedge clk); #2;
        rst_n = 1'b0;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_pair(logic r0, logic r1, logic we0, logic we1,
                            logic [31:0] a0, logic [31:0] a1,
                            logic [31:0] d0, logic [31:0] d1);
        logic [1:0] pend;
        logic [1:0] drop;
        int         waited;
        @(posedge clk); #1;
        set_m(0, r0, we0, a0, d0);
        set_m(1, r1, we1, a1, d1);
        pend   = {r1, r0};
        waited = 0;
        while (pend != 2'b00 && waited < 60) begin
            @(negedge clk);
            waited++;
            drop = 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && aout(p)) begin
                    ack_order.push_back(p);
                    drop[p] = 1'b1;
                end
            end
            pend &= ~drop;
            if (drop != 2'b00) begin
                @(posedge clk); #1;
                if (drop[0]) set_req(0, 1'b0);
                if (drop[1]) set_req(1, 1'b0);
            end
        end
        if (pend != 2'b00) begin
            n_tests++; n_fail++;
            $display("FAIL pair_timeout: pending mask 0x%0h after %0d cycles, required 0x0", pend, waited);
            set_req(0, 1'b0);
            set_req(1, 1'b0);
        end
    endtask

    task automatic req_proc(int p, int n);
        int  waited;
        bit  done;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            set_m(p, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            done   = 0;
            waited = 0;
            while (!done) begin
                @(negedge clk);
                waited++;
                if (aout(p)) begin
                    @(posedge clk); #1;
                    set_req(p, 1'b0);
                    done = 1;
                end else if (waited > 200) begin
                    n_tests++; n_fail++;
                    $display("FAIL req_timeout: port %0d waited %0d cycles, required an ack", p, waited);
                    set_req(p, 1'b0);
                    done = 1;
                end else if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                    set_m(p, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_late;
        int waited;
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Single m0 read, bridge answers two cycles after s_req_o.
        force_delay = 2; force_data_en = 1'b1; force_data = 32'h1234_5678;
        run_pair(1, 0, 0, 0, 32'h4000_0010, 32'h0, 32'h0, 32'h0);
        check("t1_ack_count", 64'(ack_order.size()), 64'd1);
        check("t1_m0_data", bus.m0_data_o, 32'h1234_5678);
        check("t1_m0_err", bus.m0_err_o, 1'b0);
        check("t1_m1_data", bus.m1_data_o, 32'h0);

        // Simultaneous requests after reset: order must alternate m0, m1, m0, m1.
        apply_reset("rst2");
        force_delay = 1; force_data_en = 1'b0;
        ack_order.delete();
        run_pair(1, 1, 0, 0, 32'h4000_0100, 32'h4000_0200, 32'h11, 32'h22);
        run_pair(1, 1, 1, 0, 32'h4000_0300, 32'h4000_0400, 32'h33, 32'h44);
        check("t2_order_len", 64'(ack_order.size()), 64'd4);
        if (ack_order.size() == 4) begin
            check("t2_order", {8'(ack_order[0]), 8'(ack_order[1]), 8'(ack_order[2]), 8'(ack_order[3])},
                  32'h0001_0001);
        end

        // m1 write: data returned is zero, bridge fields held.
        force_delay = 3;
        run_pair(0, 1, 0, 1, 32'h0, 32'h4000_0020, 32'h0, 32'hA5A5_A5A5);
        check("t3_m1_data", bus.m1_data_o, 32'h0);
        check("t3_m1_err", bus.m1_err_o, 1'b0);
        check("t3_s_fields", {bus.s_we_o, bus.s_addr_o, bus.s_data_o}, {1'b1, 32'h4000_0020, 32'hA5A5_A5A5});

        // Timeout with a late bridge ack, then a normal read.
        force_delay = T + 2;
        run_pair(1, 0, 0, 0, 32'h4000_0030, 32'h0, 32'h0, 32'h0);
        check("t4_err", bus.m0_err_o, 1'b1);
        check("t4_data", bus.m0_data_o, 32'h0);
        force_delay = 2; force_data_en = 1'b1; force_data = 32'h0BAD_BEEF;
        run_pair(1, 0, 0, 0, 32'h4000_0034, 32'h0, 32'h0, 32'h0);
        check("t4b_err", bus.m0_err_o, 1'b0);
        check("t4b_data", bus.m0_data_o, 32'h0BAD_BEEF);

        // Ack in the very cycle the timeout would fire.
        force_delay = T; force_data = 32'hCAFE_F00D;
        run_pair(1, 0, 0, 0, 32'h4000_0038, 32'h0, 32'h0, 32'h0);
        check("t5_err", bus.m0_err_o, 1'b0);
        check("t5_data", bus.m0_data_o, 32'hCAFE_F00D);

        // Randomized traffic from both requesters.
        force_delay = 0; force_data_en = 1'b0;
        fork
            req_proc(0, 40);
            req_proc(1, 40);
        join
        repeat (4) @(posedge clk);

        // Reset while in WAIT; the bridge ack then lands after release.
        force_delay = 5;
        @(posedge clk); #1;
        set_m(0, 1'b1, 1'b0, 32'h4000_0050, 32'h0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.s_req_o && waited < 20);
        check("t7_sreq_seen", bus.s_req_o, 1'b1);
        @(posedge clk);
        @(posedge clk);
        apply_reset("rst7");
        n_late = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.m0_ack_o || bus.m1_ack_o) n_late++;
        end
        check("t7_late_ack_ignored", 64'(n_late), 64'd0);
        check("t7_idle", bus.busy_o, 1'b0);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
